early_stop_ctrl: RTL and testbench
==================================

# early_stop_ctrl

Parametrised early-termination controller for the BCH decoder datapath. Syndrome vectors for up to NUM_TP test patterns arrive streamed, one pattern per beat, in any order. The block tracks which patterns have arrived and which have all-zero syndromes. It issues a single stop pulse carrying the highest-priority (lowest-index) zero-syndrome pattern as soon as that choice can no longer change. It sits between the syndrome calculators and the Berlekamp/Chien stage, which it bypasses on a stop.

## Interface

Parameters:
- NUM_TP, 4: number of test patterns per frame (2..8).
- NUM_SYN, 4: syndromes per pattern (even, ≥2).
- SYN_W, 10: syndrome width in bits.
- TPW, 4: width of o_stop_tp; must satisfy 2^TPW > NUM_TP.

Ports:
- i_clk  in  1  clock, rising edge.
- i_rst_n  in  1  reset, asynchronous, active-low.
- i_start  in  1  one-cycle frame start; samples i_mode and i_code.
- i_mode  in  1  0 = hard decision (pattern 0 only), 1 = soft decision (all NUM_TP patterns).
- i_code  in  2  2'b10 checks all NUM_SYN syndromes; any other value checks only the lower NUM_SYN/2.
- i_syn  in  NUM_SYN*SYN_W  packed syndromes; syndrome s occupies bits [s*SYN_W +: SYN_W].
- i_syn_tp  in  3  0-based pattern index of the current beat.
- i_syn_valid  in  1  beat valid.
- o_stop_pulse  out  1  one-cycle pulse: zero-syndrome pattern selected.
- o_fail_pulse  out  1  one-cycle pulse: all expected patterns received, none zero.
- o_stop_tp  out  TPW  selected pattern, 1-based; 0 = none. Held until the next i_start.
- o_zero_map  out  NUM_TP  bit k set when pattern k is received with zero syndromes.
- o_busy  out  1  high in COLLECT.

## Operation

- FSM states: IDLE, COLLECT, DONE.
  - IDLE → COLLECT on i_start.
  - COLLECT → DONE when a stop or fail is decided.
  - DONE → COLLECT on i_start.
  - i_start in COLLECT restarts the frame: maps cleared, mode and code resampled, no pulse.
- On i_start: recv_map, zero_map and o_stop_tp clear to 0; mode_q and code_q latch.
- Beat acceptance: only in COLLECT, with i_syn_valid=1, i_syn_tp < NUM_TP, and i_syn_tp not already received. When mode_q=0, additionally i_syn_tp must be 0. All other beats are silently dropped.
- Accepted beat k: recv_map[k] ← 1; zero_map[k] ← (all checked syndromes == 0).
- Expected set E: {0} when mode_q=0; all NUM_TP patterns when mode_q=1.
- Stop decision: let k be the lowest index with zero_map[k]=1 such that recv_map[j]=1 and zero_map[j]=0 for every j<k. When such k exists:
  - o_stop_pulse asserts;
  - o_stop_tp ← k+1;
  - state → DONE.
  - This can occur before the remaining patterns arrive; for example, pattern 0 zero stops immediately.
- Fail decision: all of E received and no zero pattern → o_fail_pulse asserts, o_stop_tp stays 0, state → DONE.
- The decision uses the next-state maps, so the deciding beat itself counts.
- In DONE, o_zero_map and o_stop_tp hold. Further beats are dropped.
- At most one of o_stop_pulse / o_fail_pulse asserts per frame.

## Timing

- Reset: state IDLE, all maps 0, and every output 0 (o_stop_pulse, o_fail_pulse, o_stop_tp, o_zero_map, o_busy).
- The i_start edge puts the block in COLLECT; o_busy is high from the next cycle.
- A beat in cycle t updates the maps at the edge ending t. A decision caused by that beat gives a pulse high for exactly cycle t+1, with o_stop_tp valid from t+1.
- i_start together with i_syn_valid in the same cycle: start wins and the beat is discarded.
- i_start while a pulse is high: the pulse still completes its single cycle; o_stop_tp clears in the following cycle.
- Reset asserted mid-frame: immediate return to reset values, no pulse.
- Back-to-back frames: i_start in the cycle after entering DONE is legal.

## Test plan

- Hard mode, i_code=2'b10: pattern 0 with all syndromes zero at cycle t → o_stop_pulse high at t+1 only, o_stop_tp=1, o_zero_map=4'b0001.
- Hard mode, i_code=2'b00: pattern 0 with S1=S3=0 and S5=10'h3 → stop, o_stop_tp=1. The same beat with i_code=2'b10 → o_fail_pulse, o_stop_tp=0.
- Soft mode, order tp3(zero), tp1(nonzero), tp0(nonzero), tp2(nonzero):
  - no pulse after the tp3 or tp1 beats;
  - no pulse after the tp0 beat;
  - stop after the tp2 beat, o_stop_tp=4, o_zero_map=4'b1000.
- Soft mode, tp2 zero arrives first, then tp0 and tp1 nonzero → stop at the tp1 beat with o_stop_tp=3. A later tp3 zero beat is dropped; o_zero_map stays 4'b0100.
- Soft mode, all four patterns nonzero, a duplicate tp1 beat, and an index-5 beat → exactly one o_fail_pulse, after the fourth distinct pattern.
- Reset asserted during COLLECT with two patterns received → all outputs 0 next cycle. Then i_start together with a valid beat → beat ignored, o_busy=1.

Source files
------------

// File: rtl/early_stop_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : early_stop_ctrl
//  Description : Early-termination controller for the BCH decoder datapath.
//                Collects per-test-pattern syndrome beats (any order), tracks
//                which patterns have arrived and which are all-zero, and
//                issues a single stop pulse naming the lowest-index zero
//                pattern as soon as no lower pattern can still win. If every
//                expected pattern arrives and none is zero, a fail pulse is
//                issued instead.
//  Ports       :
//    i_clk, i_rst_n  clock (rising edge), asynchronous active-low reset
//    i_start         one-cycle frame start; samples i_mode and i_code
//    i_mode          0 = hard decision (pattern 0 only), 1 = soft (all)
//    i_code          2'b10 checks all syndromes, else only the lower half
//    i_syn           packed syndromes, s at [s*SYN_W +: SYN_W]
//    i_syn_tp        0-based pattern index of the current beat
//    i_syn_valid     beat valid
//    o_stop_pulse    one-cycle pulse, zero-syndrome pattern selected
//    o_fail_pulse    one-cycle pulse, all expected received, none zero
//    o_stop_tp       selected pattern, 1-based (0 = none), held to i_start
//    o_zero_map      bit k set when pattern k received with zero syndromes
//    o_busy          high while collecting
//  Revision    : 1.0  initial release
// ============================================================================
module early_stop_ctrl #(
    parameter int NUM_TP  = 4,
    parameter int NUM_SYN = 4,
    parameter int SYN_W   = 10,
    parameter int TPW     = 4
) (
    input  logic                     i_clk,
    input  logic                     i_rst_n,
    input  logic                     i_start,
    input  logic                     i_mode,
    input  logic [1:0]               i_code,
    input  logic [NUM_SYN*SYN_W-1:0] i_syn,
    input  logic [2:0]               i_syn_tp,
    input  logic                     i_syn_valid,
    output logic                     o_stop_pulse,
    output logic                     o_fail_pulse,
    output logic [TPW-1:0]           o_stop_tp,
    output logic [NUM_TP-1:0]        o_zero_map,
    output logic                     o_busy
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COLLECT = 2'd1,
        ST_DONE    = 2'd2
    } state_t;

    state_t              r_state,   w_state_nxt;
    logic                r_mode,    w_mode_nxt;
    logic [1:0]          r_code,    w_code_nxt;
    logic [NUM_TP-1:0]   r_recv,    w_recv_nxt;
    logic [NUM_TP-1:0]   r_zero,    w_zero_nxt;
    logic [TPW-1:0]      r_stop_tp, w_stop_tp_nxt;
    logic                r_stop,    w_stop_nxt;
    logic                r_fail,    w_fail_nxt;

    logic [NUM_TP-1:0]   w_tp_onehot;
    logic                w_syn_zero;
    logic                w_accept;
    logic [NUM_TP-1:0]   w_recv_upd;
    logic [NUM_TP-1:0]   w_zero_upd;
    logic                w_found;
    logic                w_blocked;
    logic [TPW-1:0]      w_sel;
    logic                w_all_exp;

    // Out-of-range indices decode to all-zeros, which also rejects them.
    always_comb begin
        w_tp_onehot = '0;
        for (int k = 0; k < NUM_TP; k++) begin
            w_tp_onehot[k] = (i_syn_tp == 3'(k));
        end
    end

    // Upper half of the syndromes only matters for the full-strength code.
    always_comb begin
        w_syn_zero = 1'b1;
        for (int s = 0; s < NUM_SYN; s++) begin
            if (((s < NUM_SYN / 2) || (r_code == 2'b10)) &&
                (i_syn[s*SYN_W +: SYN_W] != '0)) begin
                w_syn_zero = 1'b0;
            end
        end
    end

    assign w_accept = (r_state == ST_COLLECT) && i_syn_valid &&
                      (|(w_tp_onehot & ~r_recv)) &&
                      (r_mode || w_tp_onehot[0]);

    // Maps as they would be after the current beat; the decision below looks
    // at these so the deciding beat itself is counted.
    assign w_recv_upd = r_recv | w_tp_onehot;
    assign w_zero_upd = r_zero | (w_syn_zero ? w_tp_onehot : '0);

    // Walk upward through patterns: a zero pattern wins only if every lower
    // pattern has already arrived and is nonzero; a missing lower pattern
    // blocks the choice because it could still turn out zero.
    always_comb begin
        w_found   = 1'b0;
        w_blocked = 1'b0;
        w_sel     = '0;
        for (int k = 0; k < NUM_TP; k++) begin
            if (!w_blocked) begin
                if (w_zero_upd[k]) begin
                    w_found   = 1'b1;
                    w_sel     = TPW'(k + 1);
                    w_blocked = 1'b1;
                end else if (!w_recv_upd[k]) begin
                    w_blocked = 1'b1;
                end
            end
        end
    end

    assign w_all_exp = r_mode ? (&w_recv_upd) : w_recv_upd[0];

    always_comb begin
        w_state_nxt   = r_state;
        w_mode_nxt    = r_mode;
        w_code_nxt    = r_code;
        w_recv_nxt    = r_recv;
        w_zero_nxt    = r_zero;
        w_stop_tp_nxt = r_stop_tp;
        w_stop_nxt    = 1'b0;
        w_fail_nxt    = 1'b0;

        if (i_start) begin
            // Start has priority over any beat in the same cycle.
            w_state_nxt   = ST_COLLECT;
            w_mode_nxt    = i_mode;
            w_code_nxt    = i_code;
            w_recv_nxt    = '0;
            w_zero_nxt    = '0;
            w_stop_tp_nxt = '0;
        end else if (w_accept) begin
            w_recv_nxt = w_recv_upd;
            w_zero_nxt = w_zero_upd;
            if (w_found) begin
                w_stop_nxt    = 1'b1;
                w_stop_tp_nxt = w_sel;
                w_state_nxt   = ST_DONE;
            end else if (w_all_exp && (w_zero_upd == '0)) begin
                w_fail_nxt  = 1'b1;
                w_state_nxt = ST_DONE;
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state   <= ST_IDLE;
            r_mode    <= 1'b0;
            r_code    <= 2'b00;
            r_recv    <= '0;
            r_zero    <= '0;
            r_stop_tp <= '0;
            r_stop    <= 1'b0;
            r_fail    <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_mode    <= w_mode_nxt;
            r_code    <= w_code_nxt;
            r_recv    <= w_recv_nxt;
            r_zero    <= w_zero_nxt;
            r_stop_tp <= w_stop_tp_nxt;
            r_stop    <= w_stop_nxt;
            r_fail    <= w_fail_nxt;
        end
    end

    assign o_stop_pulse = r_stop;
    assign o_fail_pulse = r_fail;
    assign o_stop_tp    = r_stop_tp;
    assign o_zero_map   = r_zero;
    assign o_busy       = (r_state == ST_COLLECT);

endmodule
`default_nettype wire

// File: tb/tb_early_stop_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_early_stop_ctrl
//  Description : Self-checking bench for early_stop_ctrl: directed frames
//                followed by randomized frames, compared every cycle against
//                a behavioural model of the stop/fail rules.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_early_stop_ctrl;

    localparam int NUM_TP  = 4;
    localparam int NUM_SYN = 4;
    localparam int SYN_W   = 10;
    localparam int TPW     = 4;
    localparam int SW      = NUM_SYN * SYN_W;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            start = 1'b0;
    logic            mode = 1'b0;
    logic [1:0]      code = 2'b00;
    logic [SW-1:0]   syn = '0;
    logic [2:0]      syn_tp = 3'd0;
    logic            syn_valid = 1'b0;
    logic            stop_pulse;
    logic            fail_pulse;
    logic [TPW-1:0]  stop_tp;
    logic [NUM_TP-1:0] zero_map;
    logic            busy;

    int n_checks = 0;
    int n_err    = 0;

    // Behavioural model state
    int  m_state = 0;   // 0 idle, 1 collecting, 2 decided
    bit  m_mode = 0;
    int  m_code = 0;
    bit  m_recv [NUM_TP];
    bit  m_zero [NUM_TP];
    int  m_tp = 0;
    bit  m_stop = 0;
    bit  m_fail = 0;

    early_stop_ctrl #(
        .NUM_TP (NUM_TP),
        .NUM_SYN(NUM_SYN),
        .SYN_W  (SYN_W),
        .TPW    (TPW)
    ) dut (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .i_start     (start),
        .i_mode      (mode),
        .i_code      (code),
        .i_syn       (syn),
        .i_syn_tp    (syn_tp),
        .i_syn_valid (syn_valid),
        .o_stop_pulse(stop_pulse),
        .o_fail_pulse(fail_pulse),
        .o_stop_tp   (stop_tp),
        .o_zero_map  (zero_map),
        .o_busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_state = 0; m_mode = 0; m_code = 0; m_tp = 0; m_stop = 0; m_fail = 0;
        for (int k = 0; k < NUM_TP; k++) begin
            m_recv[k] = 0;
            m_zero[k] = 0;
        end
    endtask

    function automatic logic [31:0] model_zmap();
        logic [31:0] v;
        v = 0;
        for (int k = 0; k < NUM_TP; k++) if (m_zero[k]) v = v + (32'd1 << k);
        return v;
    endfunction

    // Advance the model by one clock edge given this cycle's inputs.
    task automatic model_step(input bit st, input bit md, input logic [1:0] cd,
                              input bit vl, input int tp, input logic [SW-1:0] sy);
        int          nchk;
        logic [63:0] mask;
        int          j;
        bit          all_in;
        bit          any_zero;
        m_stop = 0;
        m_fail = 0;
        if (st) begin
            m_state = 1; m_mode = md; m_code = int'(cd); m_tp = 0;
            for (int k = 0; k < NUM_TP; k++) begin
                m_recv[k] = 0;
                m_zero[k] = 0;
            end
        end else if (m_state == 1 && vl && tp < NUM_TP && (m_mode || tp == 0) && !m_recv[tp]) begin
            nchk = (m_code == 2) ? NUM_SYN : NUM_SYN / 2;
            mask = (64'd1 << (nchk * SYN_W)) - 64'd1;
            m_recv[tp] = 1;
            m_zero[tp] = ((64'(sy) & mask) == 64'd0);
            // Skip over lower patterns known to be nonzero; the first one that
            // is not such decides whether a winner exists yet.
            j = 0;
            while (j < NUM_TP && m_recv[j] && !m_zero[j]) j++;
            all_in = 1; any_zero = 0;
            for (int k = 0; k < NUM_TP; k++) begin
                if (m_zero[k]) any_zero = 1;
                if ((m_mode || k == 0) && !m_recv[k]) all_in = 0;
            end
            if (j < NUM_TP && m_zero[j]) begin
                m_stop = 1; m_tp = j + 1; m_state = 2;
            end else if (all_in && !any_zero) begin
                m_fail = 1; m_state = 2;
            end
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, "_stop"}, 32'(stop_pulse), 32'(m_stop));
        chk({tag, "_fail"}, 32'(fail_pulse), 32'(m_fail));
        chk({tag, "_tp"},   32'(stop_tp),    32'(m_tp));
        chk({tag, "_zmap"}, 32'(zero_map),   model_zmap());
        chk({tag, "_busy"}, 32'(busy),       32'(m_state == 1));
    endtask

    task automatic step(input string tag, input bit st, input bit md, input logic [1:0] cd,
                        input bit vl, input logic [2:0] tp, input logic [SW-1:0] sy);
        @(negedge clk);
        start = st; mode = md; code = cd; syn_valid = vl; syn_tp = tp; syn = sy;
        model_step(st, md, cd, vl, int'(tp), sy);
        @(posedge clk);
        #1;
        check_all(tag);
    endtask

    task automatic idle(input string tag);
        step(tag, 1'b0, 1'b0, 2'b00, 1'b0, 3'd0, '0);
    endtask

    task automatic beat(input string tag, input logic [2:0] tp, input logic [SW-1:0] sy);
        step(tag, 1'b0, 1'b0, 2'b00, 1'b1, tp, sy);
    endtask

    function automatic logic [SW-1:0] rnd_syn();
        int r;
        r = $urandom_range(0, 3);
        if (r == 0) return '0;
        if (r == 1) return {20'($urandom), 20'd0};
        return SW'({$urandom, $urandom});
    endfunction

    localparam logic [SW-1:0] NZ    = 40'h00000_00001;
    localparam logic [SW-1:0] S5ONL = 40'h00_0030_0000;

    initial begin
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check_all("reset");
        @(negedge clk);
        rst_n = 1'b1;
        idle("idle0");

        // Hard mode, full code: pattern 0 zero stops at once
        step("h_start", 1, 0, 2'b10, 0, 3'd0, '0);
        beat("h_zero", 3'd0, '0);
        chk("h_zero_tp_const", 32'(stop_tp), 32'd1);
        chk("h_zero_zmap_const", 32'(zero_map), 32'h1);
        idle("h_after");

        // Hard mode, short code: only S1,S3 checked
        step("hs_start", 1, 0, 2'b00, 0, 3'd0, '0);
        beat("hs_beat", 3'd0, S5ONL);
        chk("hs_stop_const", 32'(stop_pulse), 32'd1);
        step("hf_start", 1, 0, 2'b10, 0, 3'd0, '0);
        beat("hf_beat", 3'd0, S5ONL);
        chk("hf_fail_const", 32'(fail_pulse), 32'd1);
        idle("hf_after");

        // Soft: tp3 zero, tp1, tp0, tp2 nonzero -> stop 4
        step("s1_start", 1, 1, 2'b10, 0, 3'd0, '0);
        beat("s1_tp3", 3'd3, '0);
        beat("s1_tp1", 3'd1, NZ);
        beat("s1_tp0", 3'd0, NZ);
        beat("s1_tp2", 3'd2, NZ);
        chk("s1_tp_const", 32'(stop_tp), 32'd4);
        chk("s1_zmap_const", 32'(zero_map), 32'h8);
        idle("s1_after");

        // Soft: tp2 zero first, then tp0,tp1 -> stop 3; later tp3 dropped;
        // restart while the pulse is still high
        step("s2_start", 1, 1, 2'b10, 0, 3'd0, '0);
        beat("s2_tp2", 3'd2, '0);
        beat("s2_tp0", 3'd0, NZ);
        beat("s2_tp1", 3'd1, NZ);
        chk("s2_tp_const", 32'(stop_tp), 32'd3);
        beat("s2_tp3", 3'd3, '0);
        chk("s2_zmap_const", 32'(zero_map), 32'h4);
        beat("s2_tp1b", 3'd1, '0);
        step("s2_restart", 1, 1, 2'b10, 0, 3'd0, '0);
        beat("s2r_tp0", 3'd0, '0);
        step("s2r_restart", 1, 1, 2'b10, 0, 3'd0, '0);
        idle("s2r_after");

        // Soft: all nonzero, duplicate and out-of-range beats -> one fail
        step("s3_start", 1, 1, 2'b10, 0, 3'd0, '0);
        beat("s3_tp0", 3'd0, NZ);
        beat("s3_tp1", 3'd1, NZ);
        beat("s3_dup1", 3'd1, '0);
        beat("s3_tp5", 3'd5, '0);
        beat("s3_tp2", 3'd2, NZ);
        beat("s3_tp3", 3'd3, NZ);
        chk("s3_fail_const", 32'(fail_pulse), 32'd1);
        beat("s3_late", 3'd0, '0);
        idle("s3_after");

        // Asynchronous reset mid-frame
        step("r_start", 1, 1, 2'b10, 0, 3'd0, '0);
        beat("r_tp1", 3'd1, NZ);
        beat("r_tp2", 3'd2, NZ);
        @(negedge clk);
        syn_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        check_all("r_async");
        @(posedge clk);
        #1;
        check_all("r_held");
        @(negedge clk);
        rst_n = 1'b1;
        step("r_start_beat", 1, 1, 2'b10, 1, 3'd0, '0);
        chk("r_busy_const", 32'(busy), 32'd1);
        beat("r_tp0", 3'd0, NZ);

        // Randomized frames
        for (int f = 0; f < 30; f++) begin
            step("rnd_start", 1, 1'($urandom_range(0, 1)),
                 ($urandom_range(0, 1) == 1) ? 2'b10 : 2'($urandom_range(0, 3)),
                 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), rnd_syn());
            for (int b = 0; b < 10; b++) begin
                step("rnd_beat", ($urandom_range(0, 19) == 0), 1'($urandom_range(0, 1)),
                     2'($urandom_range(0, 3)), ($urandom_range(0, 3) != 0),
                     ($urandom_range(0, 2) == 0) ? 3'($urandom_range(0, 7)) : 3'($urandom_range(0, 3)),
                     rnd_syn());
            end
        end
        idle("end");

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
